controle_elevador_param: RTL and testbench

- Parametrised elevator controller generalising the 2-bit up/down floor stepper to NUM_ANDARES floors.
- Latches per-floor call requests and moves one floor per CICLOS_VIAGEM cycles.
- Schedules with a collective (SCAN) policy: keeps direction while calls remain ahead.
- Holds the door open CICLOS_PORTA cycles at each served floor. Sits between call-button logic and floor display / motor drivers.

---
 rtl/controle_elevador_param_if.sv | 23 ++
 rtl/controle_elevador_param.sv | 143 ++++++++++++++
 tb/tb_controle_elevador_param.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/controle_elevador_param_if.sv
// Call-button / display bundle for the parametrised elevator controller.
// The controller takes the slave side; call-button logic and the displays take the master side.
interface controle_elevador_param_if #(
  parameter int NUM_ANDARES = 4,
  parameter int ANDAR_W     = 2
);
  logic [NUM_ANDARES-1:0] chamada;
  logic [ANDAR_W-1:0]     andar;
  logic                   subindo;
  logic                   descendo;
  logic                   porta_aberta;
  logic [NUM_ANDARES-1:0] pendentes;

  modport master (
    output chamada,
    input  andar, subindo, descendo, porta_aberta, pendentes
  );

  modport slave (
    input  chamada,
    output andar, subindo, descendo, porta_aberta, pendentes
  );
endinterface

// File: rtl/controle_elevador_param.sv
// Collective (SCAN) elevator controller: latches floor calls, steps one floor per
// CICLOS_VIAGEM cycles and holds the door open CICLOS_PORTA cycles at served floors.
module controle_elevador_param #(
  parameter int NUM_ANDARES   = 4,
  parameter int ANDAR_W       = 2,
  parameter int CICLOS_VIAGEM = 4,
  parameter int CICLOS_PORTA  = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  controle_elevador_param_if.slave ctl
);

  localparam logic [1:0] PARADO   = 2'd0;
  localparam logic [1:0] SUBINDO  = 2'd1;
  localparam logic [1:0] DESCENDO = 2'd2;
  localparam logic [1:0] PORTA    = 2'd3;

  localparam logic [1:0] DIR_SOBE  = 2'b01;
  localparam logic [1:0] DIR_DESCE = 2'b10;

  localparam int unsigned MAXC = (CICLOS_VIAGEM > CICLOS_PORTA) ? CICLOS_VIAGEM : CICLOS_PORTA;
  localparam int unsigned TW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [TW-1:0] FIM_VIAGEM = TW'(CICLOS_VIAGEM - 1);
  localparam logic [TW-1:0] FIM_PORTA  = TW'(CICLOS_PORTA - 1);

  logic [1:0]             r_estado;
  logic [1:0]             r_direcao;
  logic [ANDAR_W-1:0]     r_andar;
  logic [TW-1:0]          r_timer;
  logic [NUM_ANDARES-1:0] r_pend;

  logic [NUM_ANDARES-1:0] w_alvo;
  logic [NUM_ANDARES-1:0] w_clr;
  logic [ANDAR_W-1:0]     w_ref;
  logic                   w_movendo;
  logic                   w_fim_viagem;
  logic                   w_fim_porta;
  logic                   w_acima;
  logic                   w_abaixo;
  logic                   w_aqui;
  logic [1:0]             w_estado_nxt;
  logic [1:0]             w_dir_nxt;
  logic [TW-1:0]          w_timer_nxt;

  assign w_alvo       = r_pend | ctl.chamada;
  assign w_movendo    = (r_estado == SUBINDO) || (r_estado == DESCENDO);
  assign w_fim_viagem = w_movendo && (r_timer == FIM_VIAGEM);
  assign w_fim_porta  = (r_estado == PORTA) && (r_timer == FIM_PORTA);

  // Decisions at the end of a hop are taken relative to the floor being arrived at.
  always_comb begin
    w_ref = r_andar;
    if (w_fim_viagem)
      w_ref = (r_estado == SUBINDO) ? r_andar + ANDAR_W'(1) : r_andar - ANDAR_W'(1);
  end

  always_comb begin
    w_acima  = 1'b0;
    w_abaixo = 1'b0;
    w_aqui   = 1'b0;
    for (int unsigned i = 0; i < NUM_ANDARES; i++) begin
      if (w_alvo[i] && (ANDAR_W'(i) >  w_ref)) w_acima  = 1'b1;
      if (w_alvo[i] && (ANDAR_W'(i) <  w_ref)) w_abaixo = 1'b1;
      if (w_alvo[i] && (ANDAR_W'(i) == w_ref)) w_aqui   = 1'b1;
    end
  end

  always_comb begin
    w_estado_nxt = r_estado;
    w_dir_nxt    = r_direcao;
    case (r_estado)
      PARADO: begin
        if (w_aqui)                  w_estado_nxt = PORTA;
        else if (w_acima && w_abaixo) w_estado_nxt = (r_direcao == DIR_SOBE) ? SUBINDO : DESCENDO;
        else if (w_acima)            w_estado_nxt = SUBINDO;
        else if (w_abaixo)           w_estado_nxt = DESCENDO;
      end
      SUBINDO, DESCENDO: begin
        if (w_fim_viagem) begin
          if (w_aqui)
            w_estado_nxt = PORTA;
          else if ((r_estado == SUBINDO) ? w_acima : w_abaixo)
            w_estado_nxt = r_estado;
          else if ((r_estado == SUBINDO) ? w_abaixo : w_acima)
            w_estado_nxt = (r_estado == SUBINDO) ? DESCENDO : SUBINDO;
          else
            w_estado_nxt = PARADO;
        end
      end
      default: begin
        if (w_fim_porta) begin
          if ((r_direcao == DIR_SOBE) ? w_acima : w_abaixo)
            w_estado_nxt = (r_direcao == DIR_SOBE) ? SUBINDO : DESCENDO;
          else if ((r_direcao == DIR_SOBE) ? w_abaixo : w_acima)
            w_estado_nxt = (r_direcao == DIR_SOBE) ? DESCENDO : SUBINDO;
          else
            w_estado_nxt = PARADO;
        end
      end
    endcase
    if (w_estado_nxt == SUBINDO)       w_dir_nxt = DIR_SOBE;
    else if (w_estado_nxt == DESCENDO) w_dir_nxt = DIR_DESCE;
  end

  // Calls to the floor where the door is (or is about to be) open are absorbed.
  always_comb begin
    w_clr = '0;
    if ((w_estado_nxt == PORTA) || (r_estado == PORTA))
      for (int unsigned i = 0; i < NUM_ANDARES; i++)
        w_clr[i] = (ANDAR_W'(i) == w_ref);
  end

  always_comb begin
    if ((r_estado == PARADO) || w_fim_viagem || w_fim_porta)
      w_timer_nxt = '0;
    else
      w_timer_nxt = r_timer + TW'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_estado  <= PARADO;
      r_direcao <= DIR_SOBE;
      r_andar   <= '0;
      r_timer   <= '0;
      r_pend    <= '0;
    end else begin
      r_estado  <= w_estado_nxt;
      r_direcao <= w_dir_nxt;
      r_andar   <= w_ref;
      r_timer   <= w_timer_nxt;
      r_pend    <= (r_pend | ctl.chamada) & ~w_clr;
    end
  end

  assign ctl.andar        = r_andar;
  assign ctl.subindo      = (r_estado == SUBINDO);
  assign ctl.descendo     = (r_estado == DESCENDO);
  assign ctl.porta_aberta = (r_estado == PORTA);
  assign ctl.pendentes    = r_pend;

endmodule

// File: tb/tb_controle_elevador_param.sv
// Bench for controle_elevador_param: a 4-floor default instance and an 8-floor fast instance,
// checked cycle by cycle against expected output windows held in a queue.
module tb_controle_elevador_param;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  controle_elevador_param_if #(.NUM_ANDARES(4), .ANDAR_W(2)) iA ();
  controle_elevador_param_if #(.NUM_ANDARES(8), .ANDAR_W(3)) iB ();

  controle_elevador_param #(
    .NUM_ANDARES(4), .ANDAR_W(2), .CICLOS_VIAGEM(4), .CICLOS_PORTA(8)
  ) dut_a (
    .clock(clock), .reset(reset), .ctl(iA.slave)
  );

  controle_elevador_param #(
    .NUM_ANDARES(8), .ANDAR_W(3), .CICLOS_VIAGEM(2), .CICLOS_PORTA(8)
  ) dut_b (
    .clock(clock), .reset(reset), .ctl(iB.slave)
  );

  typedef struct {
    int         c0;
    int         c1;
    logic [2:0] andar;
    logic [2:0] sdp;   // {subindo, descendo, porta_aberta}
    logic [7:0] pend;
  } exp_t;

  exp_t  fila[$];
  int    n_chk = 0;
  int    n_ok  = 0;
  bit    sel_b = 1'b0;
  string cen   = "";

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp)
      $display("FAIL %s: obtido=%0h esperado=%0h", tag, obs, exp);
    else
      n_ok++;
  endtask

  task automatic espera(input int c0, input int c1, input logic [2:0] a,
                        input logic [2:0] s, input logic [7:0] p);
    exp_t e;
    e.c0 = c0; e.c1 = c1; e.andar = a; e.sdp = s; e.pend = p;
    fila.push_back(e);
  endtask

  task automatic confere(input int t);
    logic [5:0]  obs_e;
    logic [7:0]  obs_p;
    exp_t        e;
    if (sel_b) begin
      obs_e = {iB.andar, iB.subindo, iB.descendo, iB.porta_aberta};
      obs_p = iB.pendentes;
    end else begin
      obs_e = {1'b0, iA.andar, iA.subindo, iA.descendo, iA.porta_aberta};
      obs_p = {4'b0, iA.pendentes};
    end
    if (fila.size() == 0) return;
    e = fila[0];
    if (t < e.c0 || t > e.c1) return;
    verifica($sformatf("%s c%0d estado", cen, t), 32'(obs_e), 32'({e.andar, e.sdp}));
    verifica($sformatf("%s c%0d pend", cen, t), 32'(obs_p), 32'(e.pend));
    if (t == e.c1) void'(fila.pop_front());
  endtask

  task automatic reinicia();
    iA.chamada = '0;
    iB.chamada = '0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  // Runs n cycles; chamada value va is driven in cycle ca and vb in cycle cb.
  task automatic rodar(input int n, input int ca, input logic [7:0] va,
                       input int cb, input logic [7:0] vb);
    logic [7:0] ch;
    for (int t = 0; t < n; t++) begin
      @(negedge clock);
      confere(t);
      ch = (t == ca) ? va : (t == cb) ? vb : 8'h00;
      if (sel_b) begin iB.chamada = ch;       iA.chamada = '0; end
      else       begin iA.chamada = ch[3:0];  iB.chamada = '0; end
    end
    verifica($sformatf("%s fila vazia", cen), 32'(fila.size()), 32'd0);
    fila.delete();
  endtask

  initial begin
    iA.chamada = '0;
    iB.chamada = '0;

    cen = "reset";
    reinicia();
    espera(0, 0, 3'd0, 3'b000, 8'h00);
    rodar(1, -1, 8'h00, -1, 8'h00);

    cen = "t1_topo";
    reinicia();
    espera(0, 0, 3'd0, 3'b000, 8'h0);
    espera(1, 4, 3'd0, 3'b100, 8'h8);
    espera(5, 8, 3'd1, 3'b100, 8'h8);
    espera(9, 12, 3'd2, 3'b100, 8'h8);
    espera(13, 20, 3'd3, 3'b001, 8'h0);
    espera(21, 24, 3'd3, 3'b000, 8'h0);
    rodar(25, 0, 8'h08, -1, 8'h00);

    cen = "t2_local";
    reinicia();
    espera(0, 0, 3'd0, 3'b000, 8'h0);
    espera(1, 8, 3'd0, 3'b001, 8'h0);
    espera(9, 12, 3'd0, 3'b000, 8'h0);
    rodar(13, 0, 8'h01, -1, 8'h00);

    cen = "t3_parada";
    reinicia();
    espera(0, 0, 3'd0, 3'b000, 8'h0);
    espera(1, 4, 3'd0, 3'b100, 8'h8);
    espera(5, 6, 3'd1, 3'b100, 8'h8);
    espera(7, 8, 3'd1, 3'b100, 8'hC);
    espera(9, 16, 3'd2, 3'b001, 8'h8);
    espera(17, 20, 3'd2, 3'b100, 8'h8);
    espera(21, 28, 3'd3, 3'b001, 8'h0);
    espera(29, 30, 3'd3, 3'b000, 8'h0);
    rodar(31, 0, 8'h08, 6, 8'h04);

    cen = "t4_scan";
    reinicia();
    espera(0, 0, 3'd0, 3'b000, 8'h0);
    espera(1, 4, 3'd0, 3'b100, 8'h8);
    espera(5, 8, 3'd1, 3'b100, 8'h8);
    espera(9, 10, 3'd2, 3'b100, 8'h8);
    espera(11, 12, 3'd2, 3'b100, 8'h9);
    espera(13, 20, 3'd3, 3'b001, 8'h1);
    espera(21, 24, 3'd3, 3'b010, 8'h1);
    espera(25, 28, 3'd2, 3'b010, 8'h1);
    espera(29, 32, 3'd1, 3'b010, 8'h1);
    espera(33, 40, 3'd0, 3'b001, 8'h0);
    espera(41, 43, 3'd0, 3'b000, 8'h0);
    rodar(44, 0, 8'h08, 10, 8'h01);

    cen = "t5_reset";
    reinicia();
    espera(0, 0, 3'd0, 3'b000, 8'h0);
    espera(1, 4, 3'd0, 3'b100, 8'h8);
    espera(5, 7, 3'd1, 3'b100, 8'h8);
    rodar(8, 0, 8'h08, -1, 8'h00);
    #2 reset = 1'b1;
    #1;
    espera(99, 99, 3'd0, 3'b000, 8'h0);
    confere(99);
    @(negedge clock);
    reset = 1'b0;
    cen = "t5_pos";
    espera(0, 9, 3'd0, 3'b000, 8'h0);
    rodar(10, -1, 8'h00, -1, 8'h00);

    cen = "t6_oito";
    sel_b = 1'b1;
    reinicia();
    espera(0, 0, 3'd0, 3'b000, 8'h00);
    for (int k = 0; k < 7; k++)
      espera(1 + 2 * k, 2 + 2 * k, 3'(k), 3'b100, 8'h80);
    espera(15, 22, 3'd7, 3'b001, 8'h00);
    espera(23, 24, 3'd7, 3'b000, 8'h00);
    rodar(25, 0, 8'h80, -1, 8'h00);

    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

endmodule
